id_ex_pipe_stage: RTL

ID_EX_PIPE_STAGE -- requirements
Module: id_ex_pipe_stage

---
 rtl/rv32i_pkg.sv | 48 ++++
 rtl/id_ex_hazard_unit.sv | 18 +
 rtl/rv32i_control.sv | 63 ++++++
 rtl/rv32i_extend.sv | 21 ++
 rtl/id_ex_pipe_stage.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i types and default widths for decode/execute
package rv32i_pkg;

    localparam int DPW_DEFAULT = 32;
    localparam int ADW_DEFAULT = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4
    } instr_type_t;

    typedef enum logic [6:0] {
        FC_OP     = 7'h33,
        FC_OPIMM  = 7'h13,
        FC_LOAD   = 7'h03,
        FC_STORE  = 7'h23,
        FC_BRANCH = 7'h63,
        FC_LUI    = 7'h37
    } func_code_t;

    typedef struct packed {
        logic        regwrite;
        logic        resultsrc;
        logic        memwrite;
        logic        branch;
        logic        alusrc;
        alu_op_t     alu_ctrl;
        instr_type_t imm_src;
    } ctrl_t;

endpackage

// File: rtl/id_ex_hazard_unit.sv
// rtl/id_ex_hazard_unit.sv - load-use detection between the E slot and the decoding instruction
module id_ex_hazard_unit #(
    parameter int ADW = 5
) (
    input  logic           in_valid,
    input  logic           e_valid,
    input  logic           e_resultsrc,
    input  logic           e_regwrite,
    input  logic [ADW-1:0] e_rd,
    input  logic [ADW-1:0] rs1,
    input  logic [ADW-1:0] rs2,
    output logic           hazard_stall
);

    assign hazard_stall = in_valid && e_valid && e_resultsrc && e_regwrite &&
                          (e_rd != '0) && ((e_rd == rs1) || (e_rd == rs2));

endmodule

// File: rtl/rv32i_control.sv
// rtl/rv32i_control.sv - rv32i main control and ALU operation decode
module rv32i_control
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_t      ctrl
);

    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic f7, input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        ctrl = '0;
        case (opcode)
            FC_OP: begin
                ctrl.regwrite = 1'b1;
                ctrl.alu_ctrl = alu_sel(funct3, funct7_5, 1'b1);
            end
            FC_OPIMM: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_ctrl = alu_sel(funct3, funct7_5, 1'b0);
                ctrl.imm_src  = IMM_I;
            end
            FC_LOAD: begin
                ctrl.regwrite  = 1'b1;
                ctrl.resultsrc = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.imm_src   = IMM_I;
            end
            FC_STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.imm_src  = IMM_S;
            end
            FC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.imm_src  = IMM_B;
            end
            FC_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_ctrl = ALU_LUI;
                ctrl.imm_src  = IMM_U;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_extend.sv
// rtl/rv32i_extend.sv - rv32i immediate extraction and sign extension
module rv32i_extend
    import rv32i_pkg::*;
(
    input  logic [31:7]  instr,
    input  instr_type_t  imm_src,
    output logic [31:0]  imm
);

    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - decode with register file feeding a one-deep ID/EX pipeline slot
module id_ex_pipe_stage
    import rv32i_pkg::*;
#(
    parameter int DPW       = DPW_DEFAULT,
    parameter int ADW       = ADW_DEFAULT,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DPW-1:0] instrD,
    input  logic [DPW-1:0] PCD,
    input  logic           we_3,
    input  logic [ADW-1:0] addr_3,
    input  logic [DPW-1:0] wd_3,
    input  logic           flushE,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           regwriteE,
    output logic           resultsrcE,
    output logic           memwriteE,
    output logic           branchE,
    output logic           alusrcE,
    output alu_op_t        alu_ctrlE,
    output logic [DPW-1:0] srcA,
    output logic [DPW-1:0] Rd2E,
    output logic [DPW-1:0] immextE,
    output logic [DPW-1:0] PCE,
    output logic [ADW-1:0] RdE,
    output logic [ADW-1:0] Rs1E,
    output logic [ADW-1:0] Rs2E,
    output logic           hazard_stall
);

    localparam int NREG = 2**ADW;

    typedef struct packed {
        logic           valid;
        logic           regwrite;
        logic           resultsrc;
        logic           memwrite;
        logic           branch;
        logic           alusrc;
        alu_op_t        alu;
        logic [DPW-1:0] srca;
        logic [DPW-1:0] rd2;
        logic [DPW-1:0] imm;
        logic [DPW-1:0] pc;
        logic [ADW-1:0] rd;
        logic [ADW-1:0] rs1;
        logic [ADW-1:0] rs2;
    } slot_t;

    slot_t          slot_q, slot_d;
    logic [DPW-1:0] regs_q [NREG];
    logic [DPW-1:0] regs_d [NREG];
    ctrl_t          ctrl_dec;
    logic [31:0]    imm32;
    logic [DPW-1:0] imm_dp, rd1, rd2;
    logic [ADW-1:0] rs1, rs2, rd;

    assign rs1    = instrD[15 +: ADW];
    assign rs2    = instrD[20 +: ADW];
    assign rd     = instrD[7 +: ADW];
    assign imm_dp = DPW'($signed(imm32));

    rv32i_control u_control (
        .opcode   (instrD[6:0]),
        .funct3   (instrD[14:12]),
        .funct7_5 (instrD[30]),
        .ctrl     (ctrl_dec)
    );

    rv32i_extend u_extend (
        .instr   (instrD[31:7]),
        .imm_src (ctrl_dec.imm_src),
        .imm     (imm32)
    );

    id_ex_hazard_unit #(.ADW(ADW)) u_hazard (
        .in_valid     (in_valid),
        .e_valid      (slot_q.valid),
        .e_resultsrc  (slot_q.resultsrc),
        .e_regwrite   (slot_q.regwrite),
        .e_rd         (slot_q.rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .hazard_stall (hazard_stall)
    );

    // x0 is hardwired; the bypass lets a same-cycle writeback reach decode without a stall
    assign rd1 = (rs1 == '0) ? '0 :
                 (BYPASS_EN && we_3 && (addr_3 == rs1)) ? wd_3 : regs_q[rs1];
    assign rd2 = (rs2 == '0) ? '0 :
                 (BYPASS_EN && we_3 && (addr_3 == rs2)) ? wd_3 : regs_q[rs2];

    always_comb begin
        regs_d = regs_q;
        if (we_3 && (addr_3 != '0)) begin
            regs_d[addr_3] = wd_3;
        end
    end

    always_comb begin
        slot_d = slot_q;
        if (flushE) begin
            slot_d = '0;
        end else if (slot_q.valid && !out_ready) begin
            slot_d = slot_q;
        end else if (hazard_stall || !in_valid) begin
            slot_d = '0;
        end else begin
            slot_d.valid     = 1'b1;
            slot_d.regwrite  = ctrl_dec.regwrite;
            slot_d.resultsrc = ctrl_dec.resultsrc;
            slot_d.memwrite  = ctrl_dec.memwrite;
            slot_d.branch    = ctrl_dec.branch;
            slot_d.alusrc    = ctrl_dec.alusrc;
            slot_d.alu       = ctrl_dec.alu_ctrl;
            slot_d.srca      = rd1;
            slot_d.rd2       = rd2;
            slot_d.imm       = imm_dp;
            slot_d.pc        = PCD;
            slot_d.rd        = rd;
            slot_d.rs1       = rs1;
            slot_d.rs2       = rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            slot_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign in_ready   = (!slot_q.valid || out_ready) && !hazard_stall;
    assign out_valid  = slot_q.valid;
    assign regwriteE  = slot_q.regwrite;
    assign resultsrcE = slot_q.resultsrc;
    assign memwriteE  = slot_q.memwrite;
    assign branchE    = slot_q.branch;
    assign alusrcE    = slot_q.alusrc;
    assign alu_ctrlE  = slot_q.alu;
    assign srcA       = slot_q.srca;
    assign Rd2E       = slot_q.rd2;
    assign immextE    = slot_q.imm;
    assign PCE        = slot_q.pc;
    assign RdE        = slot_q.rd;
    assign Rs1E       = slot_q.rs1;
    assign Rs2E       = slot_q.rs2;

endmodule
